// File: rtl/larpix_piso_rx_if.sv
// Packet handshake bundle between the PISO receiver and its consumer.
// The master side drives the head-of-FIFO packet and its valid flag.
interface larpix_piso_rx_if #(
  parameter int WIDTH = 64
) ();
  logic [WIDTH-1:0] packet_out;
  logic             packet_parity_err;
  logic             packet_valid;
  logic             packet_ready;

  modport master (
    output packet_out,
    output packet_parity_err,
    output packet_valid,
    input  packet_ready
  );

  modport slave (
    input  packet_out,
    input  packet_parity_err,
    input  packet_valid,
    output packet_ready
  );
endinterface

// File: rtl/larpix_piso_rx.sv
// Receive-side deserializer for one LArPix PISO UART lane: start/stop framing,
// odd-parity check, and a first-word-fall-through packet FIFO.
module larpix_piso_rx #(
  parameter int WIDTH      = 64,
  parameter int CLKDIV     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 piso,
  larpix_piso_rx_if.master     pkt,
  output logic                 framing_error,
  output logic [7:0]           overflow_count,
  output logic [15:0]          rx_count,
  output logic                 busy
);

  localparam int DW = $clog2(CLKDIV) + 1;
  localparam int AW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = AW - 1;

  localparam logic [DW-1:0] HALF_M1  = DW'(CLKDIV / 2 - 1);
  localparam logic [DW-1:0] FULL_M1  = DW'(CLKDIV - 1);
  localparam logic [6:0]    LAST_BIT = 7'(WIDTH - 1);
  localparam logic [AW-1:0] DEPTH_A  = AW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  // Odd parity: a good packet has an odd number of ones.
  function automatic logic odd_parity_err(input logic [WIDTH-1:0] d);
    return ~(^d);
  endfunction

  logic [1:0]       sync_r;
  logic             rx_s;
  state_t           state_r;
  logic [DW-1:0]    div_cnt_r;
  logic [6:0]       bit_cnt_r;
  logic [WIDTH-1:0] shreg_r;
  logic             busy_r;
  logic             framing_error_r;
  logic             push_pend_r;
  logic [WIDTH:0]   push_data_r;

  logic [WIDTH:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_r;
  logic [AW-1:0]    rd_r;
  logic             valid_r;
  logic [WIDTH:0]   head_r;
  logic [15:0]      rx_count_r;
  logic [7:0]       overflow_count_r;

  logic             pop_s;
  logic             push_s;
  logic             ovf_s;
  logic             full_s;
  logic [AW-1:0]    count_s;
  logic [AW-1:0]    remain_s;
  logic [AW-1:0]    rd_n_s;
  logic [AW-1:0]    wr_n_s;
  logic [WIDTH:0]   head_n_s;

  assign rx_s = sync_r[1];

  // Two-flop synchronizer for the serial line; idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], piso};
    end
  end

  // Frame FSM: start-bit qualification, LSB-first shift, stop-bit check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= IDLE;
      div_cnt_r       <= '0;
      bit_cnt_r       <= 7'd0;
      shreg_r         <= '0;
      busy_r          <= 1'b0;
      framing_error_r <= 1'b0;
      push_pend_r     <= 1'b0;
      push_data_r     <= '0;
    end else begin
      framing_error_r <= 1'b0;
      push_pend_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r   <= START;
            div_cnt_r <= '0;
            busy_r    <= 1'b1;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        START: begin
          if (div_cnt_r == HALF_M1) begin
            div_cnt_r <= '0;
            if (!rx_s) begin
              state_r   <= DATA;
              bit_cnt_r <= 7'd0;
            end else begin
              // Line went back high before mid start bit: a glitch, not a frame.
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
          end
        end
        DATA: begin
          if (div_cnt_r == FULL_M1) begin
            div_cnt_r <= '0;
            shreg_r   <= {rx_s, shreg_r[WIDTH-1:1]};
            if (bit_cnt_r == LAST_BIT) begin
              state_r <= STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 7'd1;
            end
          end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
          end
        end
        STOP: begin
          if (div_cnt_r == FULL_M1) begin
            div_cnt_r <= '0;
            if (rx_s) begin
              push_pend_r <= 1'b1;
              push_data_r <= {odd_parity_err(shreg_r), shreg_r};
              state_r     <= IDLE;
              busy_r      <= 1'b0;
            end else begin
              framing_error_r <= 1'b1;
              state_r         <= WAIT_HIGH;
            end
          end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= WAIT_HIGH;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO control; a pop in the same cycle frees the slot for a push when full.
  always_comb begin
    pop_s    = valid_r & pkt.packet_ready;
    count_s  = wr_r - rd_r;
    full_s   = (count_s == DEPTH_A);
    push_s   = push_pend_r & (~full_s | pop_s);
    ovf_s    = push_pend_r & full_s & ~pop_s;
    rd_n_s   = rd_r + AW'(pop_s);
    wr_n_s   = wr_r + AW'(push_s);
    remain_s = count_s - AW'(pop_s);
    head_n_s = head_r;
    if (wr_n_s != rd_n_s) begin
      if (push_s && (remain_s == '0)) begin
        head_n_s = push_data_r;
      end else begin
        head_n_s = mem_r[rd_n_s[IW-1:0]];
      end
    end else begin
      head_n_s = head_r;
    end
  end

  // FIFO storage; contents are only observed through the registered head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_r[IW-1:0]] <= push_data_r;
    end
  end

  // FIFO pointers, registered head/valid, and packet counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_r             <= '0;
      rd_r             <= '0;
      valid_r          <= 1'b0;
      head_r           <= '0;
      rx_count_r       <= 16'd0;
      overflow_count_r <= 8'd0;
    end else begin
      wr_r    <= wr_n_s;
      rd_r    <= rd_n_s;
      valid_r <= (wr_n_s != rd_n_s);
      head_r  <= head_n_s;
      if (push_s) begin
        rx_count_r <= rx_count_r + 16'd1;
      end
      if (ovf_s && (overflow_count_r != 8'hFF)) begin
        overflow_count_r <= overflow_count_r + 8'd1;
      end
    end
  end

  assign pkt.packet_out        = head_r[WIDTH-1:0];
  assign pkt.packet_parity_err = head_r[WIDTH];
  assign pkt.packet_valid      = valid_r;
  assign framing_error         = framing_error_r;
  assign overflow_count        = overflow_count_r;
  assign rx_count              = rx_count_r;
  assign busy                  = busy_r;

endmodule

// File: doc/larpix_piso_rx.md
Name: larpix_piso_rx

Overview:
Receive-side deserializer for one LArPix PISO UART lane. It sits directly downstream of the chip's piso[n] output, in the bench or FPGA-side model. It recovers 64-bit packets framed by start and stop bits, checks odd parity, and flags framing errors. Good packets are buffered in a first-word-fall-through FIFO with a valid/ready interface, for scoreboards and packet decoders.

Parameters:
WIDTH, 64, payload bits per packet (excludes start/stop).
CLKDIV, 4, clk cycles per UART bit; even, ≥2.
FIFO_DEPTH, 8, output FIFO entries; power of 2, ≥2.

Ports:
clk  input  1  master clock; same clock that drives the chip.
reset_n  input  1  asynchronous digital reset, active low.
piso  input  1  serial line from chip; idle high; LSB first.
packet_out  output  WIDTH  head-of-FIFO packet.
packet_parity_err  output  1  head-of-FIFO packet failed odd parity.
packet_valid  output  1  FIFO not empty.
packet_ready  input  1  consumer accepts head when valid & ready.
framing_error  output  1  one-cycle pulse when the stop bit is sampled low.
overflow_count  output  8  packets dropped because the FIFO was full; saturates at 255.
rx_count  output  16  packets accepted into the FIFO; wraps 65535→0.
busy  output  1  FSM not in IDLE.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, FIFO empty, synchronizer flops set to 1.
- Input sync: piso passes through 2 flops → rx_s. All sampling uses rx_s.
- Bit counter: 7-bit bit_cnt. Cycle counter: $clog2(CLKDIV)+1 bits, div_cnt.
- FSM states:
  - IDLE: rx_s==0 → START, div_cnt=0.
  - START: when div_cnt==CLKDIV/2-1 (mid start bit), sample rx_s. If 0 → DATA, div_cnt=0, bit_cnt=0. If 1 → treat as glitch, go to IDLE, no error.
  - DATA: when div_cnt==CLKDIV-1, shift rx_s into shreg[bit_cnt] (LSB first) and reset div_cnt. After bit WIDTH-1 → STOP.
  - STOP: when div_cnt==CLKDIV-1, sample rx_s.
    - If 1: push {parity_err, shreg} when the FIFO is not full, else increment overflow_count. Go to IDLE.
    - If 0: pulse framing_error, discard the packet, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. Prevents mid-frame resync.
- Parity: parity_err = ~(^shreg). The packet is good when XOR of all WIDTH bits ==1. Parity-failed packets are still pushed, with the flag set.
- Latency: stop bit sampled on edge N → FIFO write on edge N+1 → packet_valid high after edge N+1. End-to-end, that is 2 sync cycles plus the frame time.
- FIFO:
  - FWFT. packet_out and packet_parity_err are valid whenever packet_valid=1 and are undefined-stable (hold last) when empty.
  - Pop occurs on valid & ready. Pointers are $clog2(FIFO_DEPTH)+1 bits; wrap is natural.
  - Simultaneous push & pop when full: the pop frees a slot, so the push succeeds with no overflow.
  - Simultaneous push & pop when empty: the push is stored, and the pop is ignored because valid was 0.
- rx_count increments on each successful push, including parity-failed packets.
- overflow_count holds at 255.
- reset_n asserted mid-frame: FSM returns to IDLE asynchronously, FIFO flushes, counters clear, and the partial packet is lost.
- piso held low after reset: START→DATA→STOP runs, the stop bit samples 0, framing_error pulses once, then the FSM waits in WAIT_HIGH.

Test Plan:
- Single packet: serialize 64'h8000_0000_0000_0001 (XOR=0, so parity fails) and then 64'h8000_0000_0000_0003 (XOR=1) with CLKDIV=4, ready=1.
  → Two valid pulses: first packet with parity_err=1, second with parity_err=0. rx_count=2.
- Backpressure/overflow: ready=0, send 10 good packets with FIFO_DEPTH=8.
  → valid held. overflow_count=2, rx_count=8.
  → Then ready=1: 8 packets drain in order, matching the first 8 sent.
- Framing error: send 64'h1 with the stop bit forced to 0, then line high 3 bit-times, then a good packet 64'hA5.
  → framing_error pulses exactly once, first packet absent, 64'hA5 received.
- Glitch rejection: a 1-cycle low pulse on piso while IDLE.
  → FSM returns to IDLE, no packet, no error, busy deasserts within CLKDIV/2+3 cycles.
- Reset mid-frame: assert reset_n after 30 data bits, release, then send 64'h3.
  → After release all outputs are 0 and the FIFO is empty. 64'h3 is then received correctly with rx_count=1.
- Back-to-back frames with no idle gap between stop and next start: 4 packets.
  → All 4 received in order. Simultaneous push/pop with ready=1 loses none.
